// File: rtl/tl_pkg.sv
// ----------------------------------------------------------------------------
// tl_pkg
// Shared TileLink-UL definitions for the memory-port arbiter:
//   - A-channel opcodes (Get, PutFullData, PutPartialData)
//   - D-channel opcodes (AccessAck, AccessAckData)
//   - A-channel FSM state type
//   - tl_beats(): number of A-channel beats a request occupies
// ----------------------------------------------------------------------------
package tl_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;

    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic {
        A_IDLE  = 1'b0,
        A_BURST = 1'b1
    } a_state_e;

    // Only Put requests larger than one beat carry multiple data beats.
    // Oversized requests are clamped so a malformed size can never hang the lock.
    function automatic int unsigned tl_beats(
        input logic [2:0]  opcode,
        input logic [2:0]  size,
        input int unsigned lg_bb,
        input int unsigned max_beats
    );
        int unsigned sz;
        int unsigned b;
        sz = 32'(size);
        b  = 1;
        if ((opcode == TL_PUT_FULL || opcode == TL_PUT_PARTIAL) && sz > lg_bb)
            b = 32'd1 << (sz - lg_bb);
        if (b > max_beats)
            b = max_beats;
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: selects the first asserted request
// at or after the pointer, wrapping cyclically (N must be a power of two).
// Ports:
//   i_req [N]      request vector
//   i_ptr [IDX_W]  highest-priority index
//   o_gnt [N]      one-hot grant (all zero when nothing requests)
//   o_idx [IDX_W]  granted index (equals i_ptr when nothing requests)
//   o_any          at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_gnt  = '0;
        o_idx  = i_ptr;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = i_ptr + IDX_W'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
        if (o_any)
            o_gnt[o_idx] = 1'b1;
    end

endmodule

// File: rtl/tl_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tl_mem_arbiter
// Shares one TileLink-UL memory port between N_MASTERS requesters.
// A channel: round-robin grant, locked for the whole of a multi-beat Put burst;
// the master index is prepended to the source. D channel: routed back by the
// top source bits. Both channels are zero-latency combinational paths.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m_a_*   (in, per master)   A requests; m_a_ready (out) per master
//   mem_a_* (out)              A request to memory; mem_a_ready (in)
//   mem_d_* (in)               D response from memory; mem_d_ready (out)
//   m_d_*   (out)              D broadcast fields, m_d_valid one-hot per master;
//                              m_d_ready (in) per master
//   perf_grant_cnt (out)       only with TLARB_PERF_EN: 16-bit saturating
//                              completed-request counter per master
// Build option: TLARB_PERF_EN enables the per-master grant counters.
// ----------------------------------------------------------------------------
module tl_mem_arbiter
    import tl_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS*3-1:0]         m_a_opcode,
    input  logic [N_MASTERS*3-1:0]         m_a_param,
    input  logic [N_MASTERS*3-1:0]         m_a_size,
    input  logic [N_MASTERS*(4-$clog2(N_MASTERS))-1:0] m_a_source,
    input  logic [N_MASTERS*ADDR_W-1:0]    m_a_address,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_a_mask,
    input  logic [N_MASTERS*DATA_W-1:0]    m_a_data,
    input  logic [N_MASTERS-1:0]           m_a_valid,
    output logic [N_MASTERS-1:0]           m_a_ready,
    output logic [2:0]                     mem_a_opcode,
    output logic [2:0]                     mem_a_param,
    output logic [2:0]                     mem_a_size,
    output logic [3:0]                     mem_a_source,
    output logic [ADDR_W-1:0]              mem_a_address,
    output logic [DATA_W/8-1:0]            mem_a_mask,
    output logic [DATA_W-1:0]              mem_a_data,
    output logic                           mem_a_valid,
    input  logic                           mem_a_ready,
    input  logic [2:0]                     mem_d_opcode,
    input  logic [1:0]                     mem_d_param,
    input  logic [2:0]                     mem_d_size,
    input  logic [3:0]                     mem_d_source,
    input  logic [1:0]                     mem_d_sink,
    input  logic                           mem_d_denied,
    input  logic [DATA_W-1:0]              mem_d_data,
    input  logic                           mem_d_corrupt,
    input  logic                           mem_d_valid,
    output logic                           mem_d_ready,
    output logic [2:0]                     m_d_opcode,
    output logic [1:0]                     m_d_param,
    output logic [2:0]                     m_d_size,
    output logic [3-$clog2(N_MASTERS):0]   m_d_source,
    output logic [1:0]                     m_d_sink,
    output logic                           m_d_denied,
    output logic [DATA_W-1:0]              m_d_data,
    output logic                           m_d_corrupt,
    output logic [N_MASTERS-1:0]           m_d_valid,
    input  logic [N_MASTERS-1:0]           m_d_ready
`ifdef TLARB_PERF_EN
    ,
    output logic [N_MASTERS*16-1:0]        perf_grant_cnt
`endif
);

    localparam int          IDX_W = $clog2(N_MASTERS);
    localparam int          SRC_W = 4 - IDX_W;
    localparam int          BB    = DATA_W / 8;
    localparam int unsigned LG_BB = $clog2(BB);
    localparam int unsigned MAXB  = MAX_BEATS;
    localparam int          CNT_W = $clog2(MAX_BEATS + 1);

    a_state_e               r_state;
    a_state_e               w_state_nxt;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_lock_idx;
    logic [CNT_W-1:0]       r_beat_cnt;

    logic [N_MASTERS-1:0]   w_rr_gnt;
    logic [IDX_W-1:0]       w_rr_idx;
    logic                   w_rr_any;
    logic [N_MASTERS-1:0]   w_gnt_oh;
    logic [IDX_W-1:0]       w_gidx;
    logic                   w_avalid;
    logic                   w_hs;
    logic                   w_last;
    logic [CNT_W-1:0]       w_beats;
    logic [IDX_W-1:0]       w_didx;

    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req (m_a_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // During a burst the holder keeps the port even while its valid is low.
    always_comb begin
        if (r_state == A_BURST) begin
            w_gidx   = r_lock_idx;
            w_gnt_oh = N_MASTERS'(1) << r_lock_idx;
            w_avalid = m_a_valid[r_lock_idx];
        end else begin
            w_gidx   = w_rr_idx;
            w_gnt_oh = w_rr_gnt;
            w_avalid = w_rr_any;
        end
    end

    assign mem_a_opcode  = m_a_opcode[w_gidx*3 +: 3];
    assign mem_a_param   = m_a_param[w_gidx*3 +: 3];
    assign mem_a_size    = m_a_size[w_gidx*3 +: 3];
    assign mem_a_source  = {w_gidx, m_a_source[w_gidx*SRC_W +: SRC_W]};
    assign mem_a_address = m_a_address[w_gidx*ADDR_W +: ADDR_W];
    assign mem_a_mask    = m_a_mask[w_gidx*BB +: BB];
    assign mem_a_data    = m_a_data[w_gidx*DATA_W +: DATA_W];
    assign mem_a_valid   = w_avalid & ~rst;
    assign m_a_ready     = rst ? '0 : (w_gnt_oh & {N_MASTERS{mem_a_ready}});

    assign w_hs    = w_avalid & mem_a_ready & ~rst;
    assign w_beats = CNT_W'(tl_beats(mem_a_opcode, mem_a_size, LG_BB, MAXB));

    // >= rather than == so a size change mid-burst still releases the lock.
    always_comb begin
        w_last      = 1'b0;
        w_state_nxt = r_state;
        if (w_hs) begin
            if (r_state == A_IDLE)
                w_last = (w_beats <= CNT_W'(1));
            else
                w_last = ((r_beat_cnt + CNT_W'(1)) >= w_beats);
        end
        case (r_state)
            A_IDLE:  if (w_hs && !w_last) w_state_nxt = A_BURST;
            A_BURST: if (w_last)          w_state_nxt = A_IDLE;
            default:                      w_state_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= A_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (r_state == A_IDLE && w_hs && !w_last) begin
                r_lock_idx <= w_gidx;
                r_beat_cnt <= CNT_W'(1);
            end else if (r_state == A_BURST && w_hs) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_last)
                r_rr_ptr <= w_gidx + IDX_W'(1);
        end
    end

    // D channel: the top source bits name the master that issued the request.
    assign w_didx      = mem_d_source[3 -: IDX_W];
    assign m_d_valid   = rst ? '0 : (N_MASTERS'(mem_d_valid) << w_didx);
    assign mem_d_ready = m_d_ready[w_didx] & ~rst;
    assign m_d_opcode  = mem_d_opcode;
    assign m_d_param   = mem_d_param;
    assign m_d_size    = mem_d_size;
    assign m_d_source  = mem_d_source[SRC_W-1:0];
    assign m_d_sink    = mem_d_sink;
    assign m_d_denied  = mem_d_denied;
    assign m_d_data    = mem_d_data;
    assign m_d_corrupt = mem_d_corrupt;

`ifdef TLARB_PERF_EN
    logic [N_MASTERS*16-1:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_perf_cnt <= '0;
        else if (w_last && r_perf_cnt[w_gidx*16 +: 16] != 16'hFFFF)
            r_perf_cnt[w_gidx*16 +: 16] <= r_perf_cnt[w_gidx*16 +: 16] + 16'd1;
    end

    assign perf_grant_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tl_mem_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a request-level reference model (pointer, holder, beats left).
// ----------------------------------------------------------------------------
module tb_tl_mem_arbiter;

    localparam int N     = 2;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BB    = DW / 8;
    localparam int IDX_W = 1;
    localparam int SRC_W = 4 - IDX_W;
    localparam int MAXB  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*3-1:0]      m_a_opcode, m_a_param, m_a_size;
    logic [N*SRC_W-1:0]  m_a_source;
    logic [N*AW-1:0]     m_a_address;
    logic [N*BB-1:0]     m_a_mask;
    logic [N*DW-1:0]     m_a_data;
    logic [N-1:0]        m_a_valid, m_a_ready;
    logic [2:0]          mem_a_opcode, mem_a_param, mem_a_size;
    logic [3:0]          mem_a_source;
    logic [AW-1:0]       mem_a_address;
    logic [BB-1:0]       mem_a_mask;
    logic [DW-1:0]       mem_a_data;
    logic                mem_a_valid, mem_a_ready;
    logic [2:0]          mem_d_opcode, mem_d_size;
    logic [1:0]          mem_d_param, mem_d_sink;
    logic [3:0]          mem_d_source;
    logic                mem_d_denied, mem_d_corrupt, mem_d_valid, mem_d_ready;
    logic [DW-1:0]       mem_d_data;
    logic [2:0]          m_d_opcode, m_d_size;
    logic [1:0]          m_d_param, m_d_sink;
    logic [SRC_W-1:0]    m_d_source;
    logic                m_d_denied, m_d_corrupt;
    logic [DW-1:0]       m_d_data;
    logic [N-1:0]        m_d_valid, m_d_ready;
`ifdef TLARB_PERF_EN
    logic [N*16-1:0]     perf_grant_cnt;
`endif

    tl_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
        .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
        .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .mem_a_opcode(mem_a_opcode), .mem_a_param(mem_a_param), .mem_a_size(mem_a_size),
        .mem_a_source(mem_a_source), .mem_a_address(mem_a_address), .mem_a_mask(mem_a_mask),
        .mem_a_data(mem_a_data), .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready),
        .mem_d_opcode(mem_d_opcode), .mem_d_param(mem_d_param), .mem_d_size(mem_d_size),
        .mem_d_source(mem_d_source), .mem_d_sink(mem_d_sink), .mem_d_denied(mem_d_denied),
        .mem_d_data(mem_d_data), .mem_d_corrupt(mem_d_corrupt), .mem_d_valid(mem_d_valid),
        .mem_d_ready(mem_d_ready),
        .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
        .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_denied(m_d_denied),
        .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid),
        .m_d_ready(m_d_ready)
`ifdef TLARB_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: next-priority master, current burst holder and beats
    // still owed by that holder, plus completed-request counts.
    int ptr       = 0;
    int hold      = -1;
    int left_b    = 0;
    int exp_perf [N];

    function automatic int beats_of(input logic [2:0] op, input logic [2:0] sz);
        int b = 1;
        if ((op == 3'd0 || op == 3'd1) && sz > 3'd3)
            b = 1 << (sz - 3'd3);
        return (b > MAXB) ? MAXB : b;
    endfunction

    function automatic int exp_grant();
        if (hold >= 0) return hold;
        for (int k = 0; k < N; k++)
            if (m_a_valid[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_m(input int m, input logic v, input logic [2:0] op,
                         input logic [2:0] sz, input logic [SRC_W-1:0] src,
                         input logic [AW-1:0] ad);
        m_a_valid[m]               = v;
        m_a_opcode[m*3 +: 3]       = op;
        m_a_param[m*3 +: 3]        = 3'($urandom);
        m_a_size[m*3 +: 3]         = sz;
        m_a_source[m*SRC_W +: SRC_W] = src;
        m_a_address[m*AW +: AW]    = ad;
        m_a_mask[m*BB +: BB]       = BB'($urandom);
        m_a_data[m*DW +: DW]       = {$urandom, $urandom};
    endtask

    // Checks all outputs for the current inputs, clocks once, advances the model.
    task automatic step(output int hs_m);
        int g;
        int b;
        logic ev;
        logic [N-1:0] er;
        int di;
        #1;
        g  = exp_grant();
        ev = (g >= 0) && m_a_valid[g] && !rst;
        er = '0;
        if (!rst && g >= 0) er[g] = mem_a_ready;
        chk("a_valid", mem_a_valid, ev);
        chk("a_ready", m_a_ready, er);
        if (ev) begin
            chk("a_source",  mem_a_source, (g << SRC_W) | m_a_source[g*SRC_W +: SRC_W]);
            chk("a_opcode",  mem_a_opcode, m_a_opcode[g*3 +: 3]);
            chk("a_param",   mem_a_param,  m_a_param[g*3 +: 3]);
            chk("a_size",    mem_a_size,   m_a_size[g*3 +: 3]);
            chk("a_address", mem_a_address, m_a_address[g*AW +: AW]);
            chk("a_mask",    mem_a_mask,   m_a_mask[g*BB +: BB]);
            chk("a_data",    mem_a_data,   m_a_data[g*DW +: DW]);
        end
        di = int'(mem_d_source) >> SRC_W;
        er = '0;
        if (!rst) er[di] = mem_d_valid;
        chk("d_valid",  m_d_valid, er);
        chk("d_ready",  mem_d_ready, !rst && m_d_ready[di]);
        chk("d_source", m_d_source, mem_d_source[SRC_W-1:0]);
        chk("d_data",   m_d_data, mem_d_data);
        chk("d_opcode", m_d_opcode, mem_d_opcode);
        hs_m = (ev && mem_a_ready) ? g : -1;
        b    = (g >= 0) ? beats_of(m_a_opcode[g*3 +: 3], m_a_size[g*3 +: 3]) : 1;
        @(posedge clk);
        if (rst) begin
            ptr = 0; hold = -1; left_b = 0;
            for (int m = 0; m < N; m++) exp_perf[m] = 0;
        end else if (hs_m >= 0) begin
            if (hold < 0) begin
                if (b > 1) begin
                    hold = hs_m; left_b = b - 1;
                end else begin
                    ptr = (hs_m + 1) % N; exp_perf[hs_m]++;
                end
            end else begin
                left_b--;
                if (left_b == 0) begin
                    hold = -1; ptr = (hs_m + 1) % N; exp_perf[hs_m]++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        int hs;
        rst = 1'b1;
        m_a_valid = '0;
        step(hs);
        rst = 1'b0;
    endtask

    int hs;
    logic [2:0]       q_op [N];
    logic [2:0]       q_sz [N];
    logic [SRC_W-1:0] q_src[N];
    logic [AW-1:0]    q_ad [N];
    int               q_left[N];
    bit               q_act[N];

    initial begin
        rst = 1'b1;
        m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
        m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_a_valid = '0;
        mem_a_ready = 1'b1;
        mem_d_opcode = 3'd1; mem_d_param = '0; mem_d_size = 3'd3; mem_d_source = 4'hA;
        mem_d_sink = '0; mem_d_denied = 1'b0; mem_d_data = 64'h1234; mem_d_corrupt = 1'b0;
        mem_d_valid = 1'b1; m_d_ready = '1;
        for (int m = 0; m < N; m++) exp_perf[m] = 0;
        @(posedge clk); #1;

        // Reset: every valid/ready output is held low.
        m_a_valid = '1;
        #1;
        chk("rst_a_valid", mem_a_valid, 0);
        chk("rst_a_ready", m_a_ready, 0);
        chk("rst_d_valid", m_d_valid, 0);
        chk("rst_d_ready", mem_d_ready, 0);
        step(hs);
        do_reset();

        // Single Get from master 1 plus its D response.
        set_m(1, 1'b1, 3'd4, 3'd3, 3'd2, 64'h200);
        mem_d_source = 4'hA; mem_d_valid = 1'b1; m_d_ready = 2'b10;
        #1;
        chk("get_src",  mem_a_source, 4'hA);
        chk("get_addr", mem_a_address, 64'h200);
        chk("get_rdy",  m_a_ready, 2'b10);
        chk("dget_vld", m_d_valid, 2'b10);
        chk("dget_src", m_d_source, 3'd2);
        chk("dget_rdy", mem_d_ready, 1);
        step(hs);
        m_a_valid = '0; mem_d_valid = 1'b0;

        // Simultaneous Gets after reset: master 0 then master 1, pointer back to 0.
        do_reset();
        set_m(0, 1'b1, 3'd4, 3'd3, 3'd1, 64'h100);
        set_m(1, 1'b1, 3'd4, 3'd3, 3'd1, 64'h300);
        #1; chk("sim_first", m_a_ready, 2'b01);
        step(hs);
        #1; chk("sim_second", m_a_ready, 2'b10);
        step(hs);
        mem_a_ready = 1'b0;
        #1; chk("sim_ptr_end", mem_a_source[3], 1'b0);
        step(hs);
        mem_a_ready = 1'b1;

        // 8-beat PutFull holds the port against a waiting Get.
        do_reset();
        set_m(0, 1'b1, 3'd0, 3'd6, 3'd3, 64'h1000);
        set_m(1, 1'b1, 3'd4, 3'd3, 3'd4, 64'h2000);
        for (int b = 0; b < 8; b++) begin
            set_m(0, 1'b1, 3'd0, 3'd6, 3'd3, 64'h1000);
            #1; chk("burst_hold", m_a_ready, 2'b01);
            step(hs);
        end
        set_m(0, 1'b1, 3'd4, 3'd3, 3'd3, 64'h1040);
        #1; chk("burst_after", m_a_ready, 2'b10);
        step(hs);
        m_a_valid[1] = 1'b0;
        step(hs);
        m_a_valid = '0;

        // Holder drops valid mid-burst: lock kept, nobody else granted.
        do_reset();
        set_m(1, 1'b1, 3'd4, 3'd3, 3'd5, 64'h2000);
        for (int b = 0; b < 11; b++) begin
            set_m(0, !(b >= 4 && b < 7), 3'd0, 3'd6, 3'd3, 64'h1000);
            #1;
            chk("drop_rdy", m_a_ready, 2'b01);
            chk("drop_vld", mem_a_valid, !(b >= 4 && b < 7));
            step(hs);
        end
        m_a_valid[0] = 1'b0;
        #1; chk("drop_after", m_a_ready, 2'b10);
        step(hs);
        m_a_valid = '0;

        // Reset after beat 3 abandons the burst.
        do_reset();
        set_m(1, 1'b1, 3'd4, 3'd3, 3'd6, 64'h2000);
        for (int b = 0; b < 3; b++) begin
            set_m(0, 1'b1, 3'd0, 3'd6, 3'd3, 64'h1000);
            step(hs);
        end
        rst = 1'b1;
        #1; chk("midrst_vld", mem_a_valid, 0);
        step(hs);
        rst = 1'b0;
        m_a_valid[0] = 1'b0;
        #1;
        chk("postrst_rdy", m_a_ready, 2'b10);
        chk("postrst_src", mem_a_source[3], 1'b1);
        step(hs);
        m_a_valid = '0;

`ifdef TLARB_PERF_EN
        do_reset();
        for (int r = 0; r < 7; r++) begin
            m_a_valid = '0;
            set_m((r < 5) ? 0 : 1, 1'b1, 3'd4, 3'd2, 3'd0, 64'h40);
            step(hs);
        end
        m_a_valid = '0;
        #1; chk("perf_cnt", perf_grant_cnt, {16'd2, 16'd5});
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int m = 0; m < N; m++) q_act[m] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < N; m++) begin
                if (!q_act[m] && $urandom_range(2) == 0) begin
                    q_act[m] = 1'b1;
                    case ($urandom_range(2))
                        0:       q_op[m] = 3'd4;
                        1:       q_op[m] = 3'd0;
                        default: q_op[m] = 3'd1;
                    endcase
                    q_sz[m]   = 3'($urandom_range(7));
                    q_src[m]  = SRC_W'($urandom);
                    q_ad[m]   = {$urandom, $urandom};
                    q_left[m] = beats_of(q_op[m], q_sz[m]);
                end
                set_m(m, q_act[m] && ($urandom_range(3) != 0), q_op[m], q_sz[m], q_src[m], q_ad[m]);
            end
            mem_a_ready  = ($urandom_range(3) != 0);
            mem_d_valid  = 1'($urandom);
            mem_d_source = 4'($urandom);
            mem_d_opcode = 3'($urandom_range(1));
            mem_d_data   = {$urandom, $urandom};
            m_d_ready    = N'($urandom);
            rst          = ($urandom_range(199) == 0);
            step(hs);
            if (rst) begin
                for (int m = 0; m < N; m++)
                    if (q_act[m]) q_left[m] = beats_of(q_op[m], q_sz[m]);
            end else if (hs >= 0) begin
                q_left[hs]--;
                if (q_left[hs] == 0) q_act[hs] = 1'b0;
            end
        end
        rst = 1'b0;
`ifdef TLARB_PERF_EN
        #1;
        for (int m = 0; m < N; m++)
            chk("perf_rand", perf_grant_cnt[m*16 +: 16], 16'(exp_perf[m]));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
